// File: rtl/llr_accum_decide_if.sv
// Handshake bundle for llr_accum_decide: LLR input stream and decision output.
// Optional OUT_MARGIN signal is present when LLR_ACC_MARGIN_EN is defined.
interface llr_accum_decide_if #(
  parameter int LLR_BIT = 3,
  parameter int FIELD   = 3,
  parameter int SUM_BIT = 6,
  parameter int GF_BIT  = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [FIELD*LLR_BIT-1:0]   in_llr;
  logic                       out_valid;
  logic                       out_ready;
  logic [GF_BIT-1:0]          out_gf;
  logic [FIELD*SUM_BIT-1:0]   out_sum;
  logic                       out_tie;
`ifdef LLR_ACC_MARGIN_EN
  logic [SUM_BIT-1:0]         out_margin;

  modport master (output in_valid, in_llr, out_ready,
                  input  in_ready, out_valid, out_gf, out_sum, out_tie, out_margin);
  modport slave  (input  in_valid, in_llr, out_ready,
                  output in_ready, out_valid, out_gf, out_sum, out_tie, out_margin);
`else
  modport master (output in_valid, in_llr, out_ready,
                  input  in_ready, out_valid, out_gf, out_sum, out_tie);
  modport slave  (input  in_valid, in_llr, out_ready,
                  output in_ready, out_valid, out_gf, out_sum, out_tie);
`endif
endinterface

// File: rtl/llr_accum_decide.sv
// Variable-node accumulate-and-decide: saturating lane-wise LLR sum over DEGREE beats,
// then argmax decision. Define LLR_ACC_MARGIN_EN to add the max-minus-runner-up margin output.
module llr_accum_decide #(
  parameter int LLR_BIT = 3,
  parameter int FIELD   = 3,
  parameter int DEGREE  = 4,
  parameter int SUM_BIT = 6,
  parameter int GF_BIT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  llr_accum_decide_if.slave bus
);

  localparam int CNT_W = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam int TC_W  = (FIELD > 1) ? $clog2(FIELD + 1) : 1;
  localparam int SW    = SUM_BIT + 1;

  typedef enum logic [1:0] {ST_ACC = 2'd0, ST_DEC = 2'd1, ST_OUT = 2'd2} state_t;

  state_t                   state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [SUM_BIT-1:0]       acc_r [FIELD];
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic [GF_BIT-1:0]        out_gf_r;
  logic [FIELD*SUM_BIT-1:0] out_sum_r;
  logic                     out_tie_r;
  logic [SUM_BIT-1:0]       max_s;
  logic [SUM_BIT-1:0]       second_s;
  logic [GF_BIT-1:0]        gf_s;
  logic [TC_W-1:0]          eq_cnt_s;
  logic                     tie_s;
  logic [SUM_BIT-1:0]       margin_s;

  // Saturating add: once a lane hits all-ones it stays there for the rest of the frame.
  function automatic logic [SUM_BIT-1:0] sat_add(input logic [SUM_BIT-1:0] a,
                                                 input logic [LLR_BIT-1:0] b);
    logic [SUM_BIT:0] s;
    s = {1'b0, a} + SW'(b);
    if (s[SUM_BIT]) begin
      sat_add = '1;
    end else begin
      sat_add = s[SUM_BIT-1:0];
    end
  endfunction

  // Argmax (lowest index wins), tie detection and runner-up for the margin.
  always_comb begin
    max_s    = '0;
    second_s = '0;
    gf_s     = '0;
    eq_cnt_s = '0;
    for (int i = 0; i < FIELD; i++) begin
      if (acc_r[i] > max_s) begin
        max_s = acc_r[i];
        gf_s  = GF_BIT'(i);
      end else begin
        max_s = max_s;
      end
    end
    for (int i = 0; i < FIELD; i++) begin
      if (acc_r[i] == max_s) begin
        eq_cnt_s = eq_cnt_s + TC_W'(1);
      end else begin
        eq_cnt_s = eq_cnt_s;
      end
      if ((i != int'(gf_s)) && (acc_r[i] > second_s)) begin
        second_s = acc_r[i];
      end else begin
        second_s = second_s;
      end
    end
    tie_s    = (eq_cnt_s > TC_W'(1));
    margin_s = max_s - second_s;
  end

`ifdef LLR_ACC_MARGIN_EN
  logic [SUM_BIT-1:0] out_margin_r;

  // Margin register, captured in DEC next to the sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_margin_r <= '0;
    end else if (state_r == ST_DEC) begin
      out_margin_r <= margin_s;
    end else begin
      out_margin_r <= out_margin_r;
    end
  end

  assign bus.out_margin = out_margin_r;
`endif

  // Main FSM: accumulate beats, decide, then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ACC;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_gf_r    <= '0;
      out_sum_r   <= '0;
      out_tie_r   <= 1'b0;
      for (int i = 0; i < FIELD; i++) acc_r[i] <= '0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (bus.in_valid && in_ready_r) begin
            for (int i = 0; i < FIELD; i++)
              acc_r[i] <= sat_add(acc_r[i], bus.in_llr[i*LLR_BIT +: LLR_BIT]);
            if (cnt_r == CNT_W'(DEGREE - 1)) begin
              cnt_r      <= '0;
              state_r    <= ST_DEC;
              in_ready_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_DEC: begin
          for (int i = 0; i < FIELD; i++) out_sum_r[i*SUM_BIT +: SUM_BIT] <= acc_r[i];
          out_gf_r    <= gf_s;
          out_tie_r   <= tie_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            for (int i = 0; i < FIELD; i++) acc_r[i] <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_ACC;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_gf    = out_gf_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_tie   = out_tie_r;

endmodule
